mem_map_router: RTL and testbench

MEM_MAP_ROUTER -- requirements
Module: mem_map_router

---
 rtl/mem_map_pkg.sv | 32 +++
 rtl/byte_lane_align.sv | 44 ++++
 rtl/mem_map_router.sv | 162 ++++++++++++++++
 tb/tb_mem_map_router.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// Shared encodings for the memory-mapped router: access sizes, FSM states
// and the default region tag table.
package mem_map_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b10;
    localparam logic [1:0] SIZE_WORD    = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    localparam int          DEFAULT_NUM_REGIONS = 3;
    localparam int          DEFAULT_TIMEOUT     = 15;
    localparam logic [47:0] DEFAULT_REGION_TAGS = {16'hffff, 16'h7fff, 16'h1000};

    // True when the size code is unusable or the address breaks natural alignment.
    function automatic logic size_illegal(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_BYTE:    bad = 1'b0;
            SIZE_HALF:    bad = lane[0];
            SIZE_WORD:    bad = |lane;
            default:      bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Combinational lane logic: byte enables, write-data lane replication and
// right-justified, zero-extended read extraction.
module byte_lane_align
    import mem_map_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  be,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_aligned
);

    logic [31:0] rdata_mask;
    logic [31:0] rdata_shifted;

    always_comb begin
        be          = 4'b1111;
        wdata_lanes = wdata;
        rdata_mask  = 32'hffff_ffff;
        case (size)
            SIZE_BYTE: begin
                be          = 4'b0001 << lane;
                wdata_lanes = {4{wdata[7:0]}};
                rdata_mask  = 32'h0000_00ff;
            end
            SIZE_HALF: begin
                be          = 4'b0011 << lane;
                wdata_lanes = {2{wdata[15:0]}};
                rdata_mask  = 32'h0000_ffff;
            end
            default: begin
                be          = 4'b1111;
                wdata_lanes = wdata;
                rdata_mask  = 32'hffff_ffff;
            end
        endcase
    end

    assign rdata_shifted = rdata_raw >> {lane, 3'b000};
    assign rdata_aligned = rdata_shifted & rdata_mask;

endmodule

// File: rtl/mem_map_router.sv
// Routes a single CPU-side access to one of NUM_REGIONS downstream regions by
// address tag, waits for that region's ack (bounded by TIMEOUT) and reports it.
module mem_map_router
    import mem_map_pkg::*;
#(
    parameter int                          NUM_REGIONS = DEFAULT_NUM_REGIONS,
    parameter logic [16*NUM_REGIONS-1:0]   REGION_TAGS = DEFAULT_REGION_TAGS,
    parameter int                          TIMEOUT     = DEFAULT_TIMEOUT
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [31:0]               addr_in,
    input  logic [31:0]               writedata_in,
    input  logic                      re_in,
    input  logic                      we_in,
    input  logic [1:0]                size_in,
    output logic [31:0]               readdata_out,
    output logic                      ready_out,
    output logic                      fault_out,
    output logic [NUM_REGIONS-1:0]    reg_sel_out,
    output logic                      reg_re_out,
    output logic                      reg_we_out,
    output logic [31:0]               reg_addr_out,
    output logic [3:0]                reg_be_out,
    output logic [31:0]               reg_wdata_out,
    input  logic [32*NUM_REGIONS-1:0] reg_rdata_in,
    input  logic [NUM_REGIONS-1:0]    reg_ack_in
);

    localparam int                  COUNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [COUNT_W-1:0]  COUNT_MAX = COUNT_W'(TIMEOUT);

    state_t                  state_reg;
    logic [31:0]             addr_reg;
    logic [1:0]              size_reg;
    logic [31:0]             wdata_reg;
    logic                    is_write_reg;
    logic [NUM_REGIONS-1:0]  sel_reg;
    logic [COUNT_W-1:0]      count_reg;
    logic [31:0]             rdata_reg;
    logic                    fault_reg;

    logic [NUM_REGIONS-1:0]  tag_match;
    logic [NUM_REGIONS-1:0]  sel_next;
    logic                    decode_legal;
    logic [31:0]             rdata_terms [NUM_REGIONS];
    logic [31:0]             rdata_sel;
    logic                    ack_sel;
    logic                    in_wait;
    logic [3:0]              be_lane;
    logic [31:0]             wdata_lane;
    logic [31:0]             rdata_aligned;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
            assign tag_match[gi]   = (addr_in[31:16] == REGION_TAGS[16*gi +: 16]);
            assign rdata_terms[gi] = reg_rdata_in[32*gi +: 32] & {32{sel_reg[gi]}};
        end
    endgenerate

    // Lowest matching index wins when several tags overlap.
    always_comb begin
        logic found;
        found    = 1'b0;
        sel_next = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (tag_match[i] && !found) begin
                sel_next[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign decode_legal = (|tag_match) && !(re_in && we_in)
                        && !size_illegal(size_in, addr_in[1:0]);

    always_comb begin
        rdata_sel = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            rdata_sel = rdata_sel | rdata_terms[i];
        end
    end

    assign ack_sel = |(reg_ack_in & sel_reg);

    byte_lane_align u_lane (
        .size          (size_reg),
        .lane          (addr_reg[1:0]),
        .wdata         (wdata_reg),
        .rdata_raw     (rdata_sel),
        .be            (be_lane),
        .wdata_lanes   (wdata_lane),
        .rdata_aligned (rdata_aligned)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            size_reg     <= SIZE_BYTE;
            wdata_reg    <= '0;
            is_write_reg <= 1'b0;
            sel_reg      <= '0;
            count_reg    <= '0;
            rdata_reg    <= '0;
            fault_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (re_in || we_in) begin
                        addr_reg     <= addr_in;
                        size_reg     <= size_in;
                        wdata_reg    <= writedata_in;
                        is_write_reg <= we_in;
                        count_reg    <= '0;
                        if (decode_legal) begin
                            sel_reg   <= sel_next;
                            state_reg <= ST_WAIT;
                        end else begin
                            sel_reg   <= '0;
                            rdata_reg <= '0;
                            fault_reg <= 1'b1;
                            state_reg <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    // An ack on the final counted cycle still completes cleanly.
                    if (ack_sel) begin
                        rdata_reg <= is_write_reg ? 32'h0 : rdata_aligned;
                        fault_reg <= 1'b0;
                        state_reg <= ST_RESP;
                    end else if (count_reg == COUNT_MAX) begin
                        rdata_reg <= '0;
                        fault_reg <= 1'b1;
                        state_reg <= ST_RESP;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                ST_RESP: begin
                    sel_reg   <= '0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign in_wait       = (state_reg == ST_WAIT);
    assign ready_out     = (state_reg == ST_RESP);
    assign readdata_out  = rdata_reg;
    assign fault_out     = fault_reg;
    assign reg_sel_out   = in_wait ? sel_reg : '0;
    assign reg_re_out    = in_wait && !is_write_reg;
    assign reg_we_out    = in_wait && is_write_reg;
    assign reg_addr_out  = in_wait ? {addr_reg[31:2], 2'b00} : 32'h0;
    assign reg_be_out    = in_wait ? be_lane : 4'h0;
    assign reg_wdata_out = in_wait ? wdata_lane : 32'h0;

endmodule

// File: tb/tb_mem_map_router.sv
// Scoreboard bench for mem_map_router: directed accesses push expected
// responses, a negedge monitor pops and checks them on every ready_out.
module tb_mem_map_router;

    logic        clk;
    logic        reset;
    logic [31:0] addr_in;
    logic [31:0] writedata_in;
    logic        re_in;
    logic        we_in;
    logic [1:0]  size_in;
    logic [31:0] readdata_out;
    logic        ready_out;
    logic        fault_out;
    logic [2:0]  reg_sel_out;
    logic        reg_re_out;
    logic        reg_we_out;
    logic [31:0] reg_addr_out;
    logic [3:0]  reg_be_out;
    logic [31:0] reg_wdata_out;
    logic [95:0] reg_rdata_in;
    logic [2:0]  reg_ack_in;

    int errors = 0;
    int checks = 0;
    int cycle_cnt = 0;

    typedef struct {
        string       name;
        logic        fault;
        logic [31:0] rdata;
        int          req_cycle;
        int          lat;
    } exp_t;
    exp_t sb[$];

    mem_map_router dut (
        .clock         (clk),
        .reset         (reset),
        .addr_in       (addr_in),
        .writedata_in  (writedata_in),
        .re_in         (re_in),
        .we_in         (we_in),
        .size_in       (size_in),
        .readdata_out  (readdata_out),
        .ready_out     (ready_out),
        .fault_out     (fault_out),
        .reg_sel_out   (reg_sel_out),
        .reg_re_out    (reg_re_out),
        .reg_we_out    (reg_we_out),
        .reg_addr_out  (reg_addr_out),
        .reg_be_out    (reg_be_out),
        .reg_wdata_out (reg_wdata_out),
        .reg_rdata_in  (reg_rdata_in),
        .reg_ack_in    (reg_ack_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (!reset && ready_out) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready_out=1 expected no response pending");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_fault"}, {31'h0, fault_out}, {31'h0, e.fault});
                chk({e.name, "_rdata"}, readdata_out, e.rdata);
                chk({e.name, "_latency"}, cycle_cnt - e.req_cycle, e.lat);
                $display("txn %s fault=%b rdata=%h latency=%0d", e.name, fault_out,
                         readdata_out, cycle_cnt - e.req_cycle);
            end
        end
    end

    task automatic do_access(
        input string       name,
        input logic [31:0] addr,
        input logic [1:0]  size,
        input logic        re,
        input logic        we,
        input logic [31:0] wdata,
        input int          ack_delay,
        input int          region,
        input logic [31:0] rdata,
        input logic        exp_fault,
        input logic [31:0] exp_rdata,
        input int          exp_lat,
        input logic [2:0]  exp_sel,
        input logic [3:0]  exp_be,
        input logic [31:0] exp_wdata
    );
        exp_t e;
        int   other;
        e.name = name; e.fault = exp_fault; e.rdata = exp_rdata;
        e.req_cycle = cycle_cnt; e.lat = exp_lat;
        sb.push_back(e);
        addr_in = addr; size_in = size; re_in = re; we_in = we; writedata_in = wdata;
        @(posedge clk); #1;
        re_in = 1'b0; we_in = 1'b0;
        chk({name, "_sel"}, {29'h0, reg_sel_out}, {29'h0, exp_sel});
        chk({name, "_be"}, {28'h0, reg_be_out}, {28'h0, exp_be});
        if (exp_sel != 3'b000) begin
            chk({name, "_strobe"}, {30'h0, reg_re_out, reg_we_out}, {30'h0, re, we});
            chk({name, "_addr"}, reg_addr_out, {addr[31:2], 2'b00});
            if (we) chk({name, "_wdata"}, reg_wdata_out, exp_wdata);
        end else begin
            chk({name, "_no_strobe"}, {30'h0, reg_re_out, reg_we_out}, 32'h0);
        end
        other = (region + 1) % 3;
        for (int j = 0; j < 40; j++) begin
            if (sb.size() == 0) break;
            if (j == ack_delay) begin
                reg_ack_in[region] = 1'b1;
                reg_rdata_in[32*region +: 32] = rdata;
            end else if (j == 0 && exp_sel != 3'b000) begin
                // Unselected region acking must be ignored
                reg_ack_in[other] = 1'b1;
                reg_rdata_in[32*other +: 32] = 32'hbad0_bad0;
            end
            @(posedge clk); #1;
            reg_ack_in = '0;
            reg_rdata_in = '0;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_no_ready: got no ready_out expected response within 40 cycles", name);
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        addr_in = '0; writedata_in = '0; re_in = 1'b0; we_in = 1'b0; size_in = 2'b00;
        reg_rdata_in = '0; reg_ack_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, ready_out}, 32'h0);
        chk("rst_fault", {31'h0, fault_out}, 32'h0);
        chk("rst_rdata", readdata_out, 32'h0);
        chk("rst_reg", {reg_sel_out, reg_re_out, reg_we_out, reg_be_out, 23'h0}, 32'h0);
        chk("rst_addr_wdata", reg_addr_out | reg_wdata_out, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        //          name      addr          sz     re    we    wdata         dly rg rdata         fault rdata_exp     lat sel     be       wdata_exp
        do_access("wr_rd",   32'h1000_0010, 2'b11, 1'b1, 1'b0, 32'h0,        0, 0, 32'hdeadbeef, 1'b0, 32'hdeadbeef, 2, 3'b001, 4'b1111, 32'h0);
        chk("hold_rdata", readdata_out, 32'hdeadbeef);
        do_access("b_wr",    32'h7fff_f003, 2'b00, 1'b0, 1'b1, 32'h0000_00a5, 1, 1, 32'h0,        1'b0, 32'h0,        3, 3'b010, 4'b1000, 32'ha5a5a5a5);
        do_access("b_rd",    32'h7fff_f003, 2'b00, 1'b1, 1'b0, 32'h0,        0, 1, 32'h12345678, 1'b0, 32'h00000012, 2, 3'b010, 4'b1000, 32'h0);
        do_access("nomatch", 32'h2000_0000, 2'b11, 1'b1, 1'b0, 32'h0,       -1, 0, 32'h0,        1'b1, 32'h0,        1, 3'b000, 4'b0000, 32'h0);
        do_access("h_mis",   32'h1000_0001, 2'b01, 1'b1, 1'b0, 32'h0,       -1, 0, 32'h0,        1'b1, 32'h0,        1, 3'b000, 4'b0000, 32'h0);
        do_access("sz10",    32'h1000_0000, 2'b10, 1'b1, 1'b0, 32'h0,       -1, 0, 32'h0,        1'b1, 32'h0,        1, 3'b000, 4'b0000, 32'h0);
        do_access("re_we",   32'h1000_0000, 2'b11, 1'b1, 1'b1, 32'h0,       -1, 0, 32'h0,        1'b1, 32'h0,        1, 3'b000, 4'b0000, 32'h0);
        do_access("h_rd",    32'hffff_0002, 2'b01, 1'b1, 1'b0, 32'h0,        0, 2, 32'habcd1234, 1'b0, 32'h0000abcd, 2, 3'b100, 4'b1100, 32'h0);
        do_access("tmo",     32'hffff_0000, 2'b11, 1'b1, 1'b0, 32'h0,       -1, 2, 32'h0,        1'b1, 32'h0,       17, 3'b100, 4'b1111, 32'h0);
        do_access("ack16",   32'hffff_0004, 2'b11, 1'b1, 1'b0, 32'h0,       15, 2, 32'hcafef00d, 1'b0, 32'hcafef00d,17, 3'b100, 4'b1111, 32'h0);
        do_access("h_wr",    32'h1000_0002, 2'b01, 1'b0, 1'b1, 32'h1234beef, 2, 0, 32'h0,        1'b0, 32'h0,        4, 3'b001, 4'b1100, 32'hbeefbeef);
        do_access("w_wr",    32'h7fff_0008, 2'b11, 1'b0, 1'b1, 32'h01020304, 0, 1, 32'h0,        1'b0, 32'h0,        2, 3'b010, 4'b1111, 32'h01020304);

        // Reset in the middle of a WAIT, then a late ack
        addr_in = 32'h1000_0010; size_in = 2'b11; re_in = 1'b1;
        @(posedge clk); #1;
        re_in = 1'b0;
        chk("abort_in_wait", {29'h0, reg_sel_out}, 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        reg_ack_in = 3'b001; reg_rdata_in[31:0] = 32'h55aa55aa;
        chk("abort_outputs", {reg_sel_out, reg_re_out, reg_we_out, reg_be_out, ready_out, fault_out, 21'h0}, 32'h0);
        chk("abort_rdata", readdata_out, 32'h0);
        @(posedge clk); #1;
        reg_ack_in = '0; reg_rdata_in = '0;
        chk("abort_no_ready", {31'h0, ready_out}, 32'h0);
        chk("abort_idle_sel", {29'h0, reg_sel_out}, 32'h0);
        repeat (2) @(posedge clk); #1;
        do_access("post_rst", 32'h1000_0010, 2'b11, 1'b1, 1'b0, 32'h0,       0, 0, 32'h87654321, 1'b0, 32'h87654321, 2, 3'b001, 4'b1111, 32'h0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
